// File: rtl/link_credit_tx.sv
// Credit-gated transmit framer feeding the MGT link: valid, credit-return, payload.
// Define LINK_CREDIT_PIGGYBACK_EN to allow credit returns on data-carrying words.
module link_credit_tx #(
  parameter int WIDTH       = 64,
  parameter int CREDITS     = 16,
  parameter int INIT_CYCLES = 100
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [WIDTH-3:0]               in_data,
  output logic                           in_ready,
  input  logic                           credit_in,
  input  logic                           credit_rel,
  output logic [WIDTH-1:0]               tx_par_data,
  output logic [$clog2(CREDITS+1)-1:0]   credit_cnt,
  output logic                           credit_err
);

  localparam int CW = $clog2(CREDITS+1);
  localparam int IW = $clog2(INIT_CYCLES+1);
  localparam logic [CW-1:0] CMAX  = CW'(CREDITS);
  localparam logic [IW-1:0] ILAST = IW'(INIT_CYCLES-1);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IW-1:0]    init_q, init_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    pend_q, pend_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-3:0] pay;
  logic             run;
  logic             accept;
  logic             ret_ok;
  logic             send_ret;

  always_comb begin
    run      = (state_q == S_RUN);
    in_ready = run && (cnt_q != '0);
    accept   = in_valid && in_ready;
`ifdef LINK_CREDIT_PIGGYBACK_EN
    ret_ok   = 1'b1;
`else
    // Returns ride only on idle words; data words never carry them.
    ret_ok   = !accept;
`endif
    send_ret = run && (pend_q != '0) && ret_ok;
    pay      = accept ? in_data : '0;
  end

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    err_d   = err_q;
    tx_d    = '0;
    case (state_q)
      S_INIT: begin
        if (init_q == ILAST) state_d = S_RUN;
        else                 init_d  = init_q + 1'b1;
      end
      S_RUN: begin
        tx_d = {accept, send_ret, pay};
        if (accept && !credit_in) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!accept && credit_in) begin
          if (cnt_q == CMAX) err_d = 1'b1;
          else               cnt_d = cnt_q + 1'b1;
        end
        if (send_ret && !credit_rel) begin
          pend_d = pend_q - 1'b1;
        end else if (!send_ret && credit_rel) begin
          if (pend_q == CMAX) err_d  = 1'b1;
          else                pend_d = pend_q + 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      init_q  <= '0;
      cnt_q   <= CMAX;
      pend_q  <= '0;
      err_q   <= 1'b0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_par_data = tx_q;
  assign credit_cnt  = cnt_q;
  assign credit_err  = err_q;

endmodule

// File: tb/tb_link_credit_tx.sv
// Bench for link_credit_tx: scenario tasks checked against a cycle-level
// arithmetic model of credits, pending returns and the init window.
module tb_link_credit_tx;

  localparam int WIDTH   = 64;
  localparam int CREDITS = 16;
  localparam int INIT    = 100;
  localparam int CW      = $clog2(CREDITS+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-3:0] in_data;
  logic             in_ready;
  logic             credit_in;
  logic             credit_rel;
  logic [WIDTH-1:0] tx_par_data;
  logic [CW-1:0]    credit_cnt;
  logic             credit_err;

  link_credit_tx #(
    .WIDTH(WIDTH), .CREDITS(CREDITS), .INIT_CYCLES(INIT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .credit_in(credit_in), .credit_rel(credit_rel),
    .tx_par_data(tx_par_data), .credit_cnt(credit_cnt),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int         since;
  int         m_cred;
  int         m_pend;
  bit         m_err;
  logic [63:0] m_tx;
  bit         piggy;

  function automatic bit m_ready();
    return (since >= INIT) && (m_cred > 0);
  endfunction

  function automatic logic [61:0] rnd62();
    return {$urandom, $urandom};
  endfunction

  // Drive one cycle at negedge, advance the model at posedge, return at negedge.
  task automatic tick(input bit r, input bit v, input logic [61:0] d,
                      input bit ci, input bit cr);
    bit acc;
    bit ret;
    rst = r; in_valid = v; in_data = d; credit_in = ci; credit_rel = cr;
    @(posedge clk);
    if (r) begin
      since = 0; m_cred = CREDITS; m_pend = 0; m_err = 0; m_tx = '0;
    end else begin
      if (since >= INIT) begin
        acc = v && (m_cred > 0);
        ret = (m_pend > 0) && (piggy || !acc);
        m_tx = {acc, ret, acc ? d : 62'd0};
        m_cred = m_cred + int'(ci) - int'(acc);
        if (m_cred > CREDITS) begin m_cred = CREDITS; m_err = 1; end
        m_pend = m_pend + int'(cr) - int'(ret);
        if (m_pend > CREDITS) begin m_pend = CREDITS; m_err = 1; end
      end else begin
        m_tx = '0;
      end
      since++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1, 0, '0, 0, 0);
    tick(1, 1, rnd62(), 1, 1);
    checks++; if (tx_par_data !== '0) begin errors++;
      $display("FAIL reset_tx: got %h want 0", tx_par_data); end
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL reset_ready: got %b want 0", in_ready); end
    checks++; if (credit_cnt !== CW'(CREDITS)) begin errors++;
      $display("FAIL reset_cnt: got %0d want %0d", credit_cnt, CREDITS); end
    checks++; if (credit_err !== 1'b0) begin errors++;
      $display("FAIL reset_err: got %b want 0", credit_err); end
    for (int i = 0; i < INIT; i++) begin
      checks++; if (tx_par_data !== '0 || in_ready !== 1'b0) begin errors++;
        $display("FAIL init_quiet[%0d]: tx=%h ready=%b want 0/0",
                 i, tx_par_data, in_ready); end
      tick(0, 1'($urandom), rnd62(), 1'($urandom), 1'($urandom));
    end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL init_done_ready: got %b want 1", in_ready); end
    checks++; if (credit_cnt !== CW'(CREDITS)) begin errors++;
      $display("FAIL init_done_cnt: got %0d want %0d", credit_cnt, CREDITS); end
  endtask

  task automatic test_burst();
    logic [63:0] exp;
    for (int i = 0; i < 22; i++) begin
      tick(0, 1, 62'(i), 0, 0);
      exp = (i < CREDITS) ? {2'b10, 62'(i)} : 64'd0;
      checks++; if (tx_par_data !== exp) begin errors++;
        $display("FAIL burst_tx[%0d]: got %h want %h", i, tx_par_data, exp); end
      checks++; if (in_ready !== (i < CREDITS-1)) begin errors++;
        $display("FAIL burst_ready[%0d]: got %b want %b",
                 i, in_ready, (i < CREDITS-1)); end
      checks++; if (credit_cnt !== CW'(m_cred)) begin errors++;
        $display("FAIL burst_cnt[%0d]: got %0d want %0d", i, credit_cnt, m_cred); end
    end
  endtask

  task automatic test_credit_single();
    logic [61:0] d;
    tick(0, 0, '0, 1, 0);
    checks++; if (in_ready !== 1'b1 || credit_cnt !== CW'(1)) begin errors++;
      $display("FAIL single_ready: ready=%b cnt=%0d want 1/1", in_ready, credit_cnt); end
    d = rnd62();
    tick(0, 1, d, 0, 0);
    checks++; if (tx_par_data !== {2'b10, d}) begin errors++;
      $display("FAIL single_word: got %h want %h", tx_par_data, {2'b10, d}); end
    checks++; if (in_ready !== 1'b0 || credit_cnt !== '0) begin errors++;
      $display("FAIL single_empty: ready=%b cnt=%0d want 0/0", in_ready, credit_cnt); end
    for (int i = 0; i < 2; i++) begin
      tick(0, 1, rnd62(), 0, 0);
      checks++; if (tx_par_data !== '0) begin errors++;
        $display("FAIL single_after[%0d]: got %h want 0", i, tx_par_data); end
    end
  endtask

  task automatic test_simultaneous();
    logic [61:0] d;
    for (int i = 0; i < 5; i++) tick(0, 0, '0, 1, 0);
    checks++; if (credit_cnt !== CW'(5)) begin errors++;
      $display("FAIL simul_pre: got %0d want 5", credit_cnt); end
    d = rnd62();
    tick(0, 1, d, 1, 0);
    checks++; if (credit_cnt !== CW'(5)) begin errors++;
      $display("FAIL simul_cnt: got %0d want 5", credit_cnt); end
    checks++; if (tx_par_data !== {2'b10, d}) begin errors++;
      $display("FAIL simul_tx: got %h want %h", tx_par_data, {2'b10, d}); end
    for (int i = 0; i < 11; i++) tick(0, 0, '0, 1, 0);
    checks++; if (credit_cnt !== CW'(CREDITS) || credit_err !== 1'b0) begin errors++;
      $display("FAIL full_cnt: cnt=%0d err=%b want 16/0", credit_cnt, credit_err); end
    tick(0, 0, '0, 1, 0);
    checks++; if (credit_cnt !== CW'(CREDITS)) begin errors++;
      $display("FAIL ovf_cnt: got %0d want %0d", credit_cnt, CREDITS); end
    checks++; if (credit_err !== 1'b1) begin errors++;
      $display("FAIL ovf_err: got %b want 1", credit_err); end
  endtask

  task automatic test_return();
    int ret_data = 0;
    int ret_idle = 0;
    for (int i = 0; i < 18; i++) begin
      tick(0, i < 10, rnd62(), 0, (i >= 2 && i <= 4));
      checks++; if (tx_par_data !== m_tx) begin errors++;
        $display("FAIL ret_tx[%0d]: got %h want %h", i, tx_par_data, m_tx); end
      if (tx_par_data[62] && tx_par_data[63]) ret_data++;
      if (tx_par_data[62] && !tx_par_data[63]) ret_idle++;
    end
    checks++; if (ret_data + ret_idle !== 3) begin errors++;
      $display("FAIL ret_total: got %0d want 3", ret_data + ret_idle); end
    checks++; if (ret_data !== (piggy ? 3 : 0)) begin errors++;
      $display("FAIL ret_on_data: got %0d want %0d", ret_data, piggy ? 3 : 0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(0, ($urandom % 4) != 0, rnd62(), ($urandom % 3) == 0, ($urandom % 4) == 0);
      checks++; if (tx_par_data !== m_tx) begin errors++;
        $display("FAIL rnd_tx[%0d]: got %h want %h", i, tx_par_data, m_tx); end
      checks++; if (in_ready !== m_ready()) begin errors++;
        $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, m_ready()); end
      checks++; if (credit_cnt !== CW'(m_cred)) begin errors++;
        $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, credit_cnt, m_cred); end
      checks++; if (credit_err !== m_err) begin errors++;
        $display("FAIL rnd_err[%0d]: got %b want %b", i, credit_err, m_err); end
    end
  endtask

  task automatic test_reset_mid();
    tick(1, 0, '0, 0, 0);
    for (int i = 0; i < INIT; i++) tick(0, 0, '0, 0, 0);
    for (int i = 0; i < 13; i++) tick(0, 1, rnd62(), 0, (i >= 11));
    checks++; if (credit_cnt !== CW'(3) || m_pend < 1) begin errors++;
      $display("FAIL mid_pre: cnt=%0d pend=%0d want 3/>0", credit_cnt, m_pend); end
    tick(1, 1, rnd62(), 1, 1);
    checks++; if (tx_par_data !== '0 || in_ready !== 1'b0) begin errors++;
      $display("FAIL mid_rst_tx: tx=%h ready=%b want 0/0", tx_par_data, in_ready); end
    checks++; if (credit_cnt !== CW'(CREDITS) || credit_err !== 1'b0) begin errors++;
      $display("FAIL mid_rst_cnt: cnt=%0d err=%b want 16/0", credit_cnt, credit_err); end
    for (int i = 0; i < INIT; i++) begin
      checks++; if (tx_par_data !== '0 || in_ready !== 1'b0) begin errors++;
        $display("FAIL mid_init[%0d]: tx=%h ready=%b want 0/0",
                 i, tx_par_data, in_ready); end
      tick(0, 1, rnd62(), 0, 0);
    end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL mid_run_ready: got %b want 1", in_ready); end
    tick(0, 0, '0, 0, 0);
    checks++; if (tx_par_data !== '0) begin errors++;
      $display("FAIL mid_no_stale_ret: got %h want 0", tx_par_data); end
  endtask

  initial begin
`ifdef LINK_CREDIT_PIGGYBACK_EN
    piggy = 1'b1;
`else
    piggy = 1'b0;
`endif
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    credit_in = 1'b0; credit_rel = 1'b0;
    since = 0; m_cred = CREDITS; m_pend = 0; m_err = 0; m_tx = '0;
    @(negedge clk);
    test_reset();
    test_burst();
    test_credit_single();
    test_simultaneous();
    test_return();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
